apb_slave_ctrl: RTL

//  APB3 slave front-end, directly upstream of the ECC register file.
//  - Converts APB setup/access phases into register-file commands (Rd_Wr_Id, offset, data_to_reg).
//  - Returns read data to the APB master.
//  - Stalls writes while the ECC core is busy.
//  - Pulses start_op after every successful CTRL write.

---
 rtl/apb_slave_pkg.sv | 29 ++
 rtl/apb_slave_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB3 slave front-end of the ECC register file.
package apb_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] RD_WR_READ  = 2'd0;
  localparam logic [1:0] RD_WR_WRITE = 2'd1;
  localparam logic [1:0] RD_WR_IDLE  = 2'd2;

  localparam logic [3:0] OFF_CTRL     = 4'd0;
  localparam logic [3:0] OFF_DATA_IN  = 4'd1;
  localparam logic [3:0] OFF_CW_WIDTH = 4'd2;
  localparam logic [3:0] OFF_NOISE    = 4'd3;

  // Callers zero-extend PADDR to this width before decoding.
  localparam int unsigned ADDR_EXT_W = 64;

  // Word-aligned and inside the four-register window; bits [5:4] being zero is
  // exactly the offset falling in OFF_CTRL..OFF_NOISE.
  function automatic logic addr_valid(input logic [ADDR_EXT_W-1:0] addr);
    return (addr[1:0] == 2'b00) &&
           (addr[ADDR_EXT_W-1:6] == '0) &&
           (addr[5:2] inside {OFF_CTRL, OFF_DATA_IN, OFF_CW_WIDTH, OFF_NOISE});
  endfunction

endpackage

// File: rtl/apb_slave_ctrl.sv
// APB3 slave front-end: turns setup/access phases into register-file commands,
// stalls writes while the ECC core is busy and pulses start_op after CTRL writes.
module apb_slave_ctrl
  import apb_slave_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned WAIT_TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [1:0]                 Rd_Wr_Id,
  output logic [3:0]                 offset,
  output logic [AMBA_WORD-1:0]       data_to_reg,
  input  logic [AMBA_WORD-1:0]       data_out,
  input  logic                       core_busy,
  output logic                       start_op
);

  localparam int unsigned     CNT_W       = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);

  state_t                 state_q;
  logic                   valid_q;
  logic                   write_q;
  logic [3:0]             offset_q;
  logic [AMBA_WORD-1:0]   data_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic                   start_op_q;

  logic                   access;
  logic                   wr_done;
  logic                   stall;
  logic                   ready_d;
  logic                   err_d;
  logic [1:0]             rdwr_d;
  logic [AMBA_WORD-1:0]   prdata_d;

  always_comb begin
    access   = (state_q == ACCESS) && PSEL && PENABLE;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdwr_d   = RD_WR_IDLE;
    prdata_d = '0;
    wr_done  = 1'b0;
    stall    = 1'b0;
    if (access) begin
      if (!valid_q) begin
        ready_d = 1'b1;
        err_d   = 1'b1;
      end else if (!write_q) begin
        ready_d  = 1'b1;
        rdwr_d   = RD_WR_READ;
        prdata_d = data_out;
      end else if (!core_busy) begin
        ready_d = 1'b1;
        rdwr_d  = RD_WR_WRITE;
        wr_done = 1'b1;
      end else if (wait_cnt_q == TIMEOUT_CNT) begin
        ready_d = 1'b1;
        err_d   = 1'b1;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      offset_q   <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      start_op_q <= 1'b0;
    end else begin
      start_op_q <= wr_done && (offset_q == OFF_CTRL);
      case (state_q)
        IDLE: begin
          // An access phase arriving without a setup phase is ignored here.
          if (PSEL && !PENABLE) begin
            state_q    <= ACCESS;
            valid_q    <= addr_valid(ADDR_EXT_W'(PADDR));
            write_q    <= PWRITE;
            offset_q   <= PADDR[5:2];
            data_q     <= PWDATA;
            wait_cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (!PSEL || ready_d) begin
            state_q <= IDLE;
          end else if (stall) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PREADY      = ready_d;
  assign PSLVERR     = err_d;
  assign Rd_Wr_Id    = rdwr_d;
  assign PRDATA      = prdata_d;
  assign offset      = offset_q;
  assign data_to_reg = data_q;
  assign start_op    = start_op_q;

endmodule
